t04_uart_rx: RTL
================

# t04_uart_rx

Serial receiver that sits directly upstream of the team 04 core's `Rx` input. It turns the raw 8N1 asynchronous line (a push-button pin on the FPGA top) into whole bytes, delivered through a valid/ready handshake. It synchronizes the line, rejects glitch start bits, samples each bit at mid-bit, and flags framing and overrun errors. The core consumes `rx_data` when it has buffer space.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per bit period (10 MHz / 115200 baud). Legal range is 4 to 65535.
- `clk` input 1: the single clock for the whole block.
- `nRst` input 1: asynchronous, active-low reset.
- `rx_in` input 1: raw serial line. It idles high and is asynchronous to `clk`.
- `rx_ready` input 1: consumer accepts `rx_data` in any cycle where `rx_valid && rx_ready`.
- `rx_data` output 8: received byte. Held stable while `rx_valid` is high.
- `rx_valid` output 1: a byte is available.
- `framing_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_err` output 1: one-cycle pulse when a good byte is dropped.
- `parity_err` output 1: one-cycle pulse on a parity mismatch. Tied to 0 unless the parity macro is defined.
- `busy` output 1: high whenever the FSM is not IDLE.

## Operation
- `rx_in` passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronized value `rxs`.
- `HALF = CLKS_PER_BIT/2`, using integer division.
- The bit counter `cnt` is 16 bits wide and the bit index is 3 bits wide.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: when `rxs == 0`, go to START and clear `cnt`.
- START: when `cnt == HALF`, sample `rxs`.
  - If it is 1, treat it as a false start: return to IDLE with no output.
  - If it is 0, go to DATA with `cnt = 0` and bit index 0.
- DATA: sample once each time `cnt` reaches `CLKS_PER_BIT-1`, then reset `cnt`.
  - Bits arrive LSB first and shift into a shift register.
  - After bit 7, go to PARITY if it is compiled in, otherwise go to STOP.
- PARITY: sample one bit period later and compare it with even parity over the 8 data bits.
- STOP: sample one bit period later, then go to IDLE on the same edge. The FSM therefore returns to IDLE at mid-stop-bit, so a start bit that follows immediately is caught.
- Byte delivery at the stop sample:
  - Stop bit 0: pulse `framing_err`. The byte is discarded and `rx_valid` and `rx_data` are unchanged.
  - Parity mismatch (macro only): pulse `parity_err` and discard the byte.
  - Good byte with the output register free (`!rx_valid`, or `rx_ready` asserted this cycle): load `rx_data` and set `rx_valid`.
  - Good byte with `rx_valid && !rx_ready`: pulse `overrun_err` and drop the new byte. The old byte stays held.
- `rx_valid` clears on the edge after `rx_valid && rx_ready`, unless a new byte loads on that same edge. In that case `rx_valid` stays high with the new data.
- Reset, asynchronous and at any time: state = IDLE, `cnt = 0`, shift register = 0, `rx_data = 8'h00`. The outputs `rx_valid`, `framing_err`, `overrun_err`, `parity_err` and `busy` all reset to 0. Any partial frame is lost. After reset the block waits for a fresh falling edge on `rxs`.

## Timing
- Cycle 0 is the edge at which the FSM leaves IDLE. `rxs` lags `rx_in` by 2 cycles.
- The start bit is checked at the cycle-`HALF` edge.
- Data bit i is sampled at edge `HALF + (i+1)*CLKS_PER_BIT`.
- Parity, when present, is sampled at `HALF + 9*CLKS_PER_BIT`.
- The stop bit is sampled at `HALF + (9+P)*CLKS_PER_BIT`, where P is 1 with parity and 0 without.
- `rx_valid` or the error pulse is visible in the cycle after the stop sample.
- Total latency from the `rx_in` falling edge to `rx_valid` is 2 + `HALF` + (9+P)·`CLKS_PER_BIT` + 1 cycles.
- Error pulses are exactly 1 cycle wide.
- `busy` is high from cycle 1 through the cycle of the stop sample.
- Any low pulse on `rxs` shorter than `HALF`+1 cycles at a start bit produces no output.

## Configuration
- Macro: `T04_UART_RX_PARITY_EN`.
- Defined: the frame is 8E1. The PARITY state exists and `parity_err` is live.
- Undefined: the frame is 8N1. There is no PARITY state and `parity_err` is constant 0. Port list and timing follow the P = 0 case.

## Test plan
All scenarios use `CLKS_PER_BIT = 16` and no macro, except scenario 6.
1. Reset, then send byte 0xA5 with `rx_ready` held at 1 → `rx_valid` rises exactly 2+8+144+1 = 155 cycles after the start edge, with `rx_data = 0xA5`. `rx_valid` lasts 1 cycle and no errors are flagged.
2. Drive a 5-cycle low glitch on `rx_in` → `busy` is briefly high, then returns to 0. `rx_valid` and all error outputs stay 0.
3. Send 0x3C with the stop bit forced low → one `framing_err` pulse, `rx_valid` stays 0, and `rx_data` keeps its previous value.
4. Hold `rx_ready = 0` and send 0x11 then 0x22 back-to-back → `rx_valid` high with 0x11, then one `overrun_err` pulse and `rx_data` still 0x11. Raising `rx_ready` drops `rx_valid` the next cycle.
5. Assert `nRst = 0` at data bit 4 of a frame, release it, then send 0x7E → there is no output for the aborted frame and the block receives 0x7E correctly.
6. With the macro defined, send 0x01 with parity bit 0 (wrong) and then with parity bit 1 (correct) → first frame gives one `parity_err` pulse and no valid. Second frame gives `rx_valid` with 0x01.

Source files
------------

// File: rtl/t04_uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : t04_uart_rx_if
// Description : Byte handshake between the UART receiver and its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface t04_uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/t04_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : t04_uart_rx
// Description : 8N1 (8E1 with T04_UART_RX_PARITY_EN) serial receiver with
//               valid/ready byte output, framing/overrun/parity flags.
// Revision    : 1.0 - initial release
// ============================================================================
module t04_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  wire            clk,
    input  wire            nRst,
    input  wire            rx_in,
    t04_uart_rx_if.master  rxbus,
    output logic           framing_err,
    output logic           overrun_err,
    output logic           parity_err,
    output logic           busy
);

    // cnt reads 0 on the first cycle after leaving IDLE, so the start check
    // compares against HALF-1 to land on the cycle-HALF edge.
    localparam logic [15:0] C_HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] C_LAST    = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef T04_UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_sync1, r_sync2;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_ferr, w_ferr_nxt;
    logic        r_oerr, w_oerr_nxt;
`ifdef T04_UART_RX_PARITY_EN
    logic        r_perr, w_perr_nxt;
    logic        r_par_bad, w_par_bad_nxt;
`endif
    logic        w_rxs;

    assign w_rxs = r_sync2;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_oerr    <= 1'b0;
`ifdef T04_UART_RX_PARITY_EN
            r_perr    <= 1'b0;
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_sync1   <= rx_in;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
            r_oerr    <= w_oerr_nxt;
`ifdef T04_UART_RX_PARITY_EN
            r_perr    <= w_perr_nxt;
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid && !rxbus.rx_ready;
        w_ferr_nxt  = 1'b0;
        w_oerr_nxt  = 1'b0;
`ifdef T04_UART_RX_PARITY_EN
        w_perr_nxt    = 1'b0;
        w_par_bad_nxt = r_par_bad;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rxs) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == C_HALF_M1) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rxs, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef T04_UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef T04_UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt     = '0;
                    w_par_bad_nxt = (w_rxs != (^r_shift));
                    w_state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is seen.
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (!w_rxs) begin
                        w_ferr_nxt = 1'b1;
`ifdef T04_UART_RX_PARITY_EN
                    end else if (r_par_bad) begin
                        w_perr_nxt = 1'b1;
`endif
                    end else if (!r_valid || rxbus.rx_ready) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_oerr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rxbus.rx_data  = r_data;
    assign rxbus.rx_valid = r_valid;
    assign framing_err    = r_ferr;
    assign overrun_err    = r_oerr;
    assign busy           = (r_state != S_IDLE);
`ifdef T04_UART_RX_PARITY_EN
    assign parity_err     = r_perr;
`else
    assign parity_err     = 1'b0;
`endif

endmodule
`default_nettype wire
